// File: rtl/disp_capture_pkg.sv
// rtl/disp_capture_pkg.sv - shared state encoding and FIFO word layout for disp_capture
package disp_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2,
        ST_FLUSH      = 2'd3
    } state_e;

    // FIFO word is {pixel, sof, eol}; flags sit in the two LSBs
    localparam int FLAG_EOL  = 0;
    localparam int FLAG_SOF  = 1;
    localparam int FLAG_BITS = 2;

endpackage

// File: rtl/disp_capture_if.sv
// rtl/disp_capture_if.sv - display input bundle and captured pixel stream
interface disp_capture_if #(
    parameter int BPC_BOARD = 8,
    parameter int CORDW     = 16
);
    logic signed [CORDW-1:0]     disp_x;
    logic signed [CORDW-1:0]     disp_y;
    logic                        disp_de;
    logic                        disp_frame;
    logic [BPC_BOARD-1:0]        disp_r;
    logic [BPC_BOARD-1:0]        disp_g;
    logic [BPC_BOARD-1:0]        disp_b;
    logic [3*BPC_BOARD-1:0]      out_data;
    logic                        out_sof;
    logic                        out_eol;
    logic                        out_valid;
    logic                        out_ready;

    // display source and stream consumer side
    modport master (
        output disp_x, disp_y, disp_de, disp_frame, disp_r, disp_g, disp_b, out_ready,
        input  out_data, out_sof, out_eol, out_valid
    );

    // capture block side
    modport slave (
        input  disp_x, disp_y, disp_de, disp_frame, disp_r, disp_g, disp_b, out_ready,
        output out_data, out_sof, out_eol, out_valid
    );
endinterface

// File: rtl/disp_capture_fifo.sv
// rtl/disp_capture_fifo.sv - synchronous first-word-fall-through FIFO
module disp_capture_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    // full is judged on the pre-pop occupancy, so a write never rides on a same-cycle pop
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    // head word shown combinationally; zero when empty keeps the stream quiet
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage array, no reset needed since empty masks stale words
    always_ff @(posedge clk_pix) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/disp_capture.sv
// rtl/disp_capture.sv - one-shot frame capture into a pixel stream
module disp_capture
    import disp_capture_pkg::*;
#(
    parameter int BPC_BOARD  = 8,
    parameter int CORDW      = 16,
    parameter int H_RES      = 672,
    parameter int V_RES      = 384,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk_pix,
    input  logic           rst_pix_n,
    input  logic           arm,
    disp_capture_if.slave  bus,
    output logic           busy,
    output logic           done,
    output logic           overflow,
    output logic           short_frame
);
    localparam int DW = 3 * BPC_BOARD;
    localparam int WW = DW + FLAG_BITS;
    localparam logic signed [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] Y_LAST = CORDW'(V_RES - 1);

    state_e          state_q, state_d;
    logic            sof_pend_q, sof_pend_d;
    logic            overflow_q, overflow_d;
    logic            short_q, short_d;
    logic            done_q, done_d;
    logic            wr_en;
    logic [WW-1:0]   wr_data;
    logic [WW-1:0]   rd_data;
    logic            fifo_empty;
    logic            fifo_full;
    logic            rd_en;

    disp_capture_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rd_en         = !fifo_empty && bus.out_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = rd_data[FLAG_BITS +: DW];
    assign bus.out_sof   = rd_data[FLAG_SOF];
    assign bus.out_eol   = rd_data[FLAG_EOL];

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign short_frame = short_q;

    // pack the incoming pixel with its stream markers
    always_comb begin
        wr_data                     = '0;
        wr_data[FLAG_BITS +: DW]    = {bus.disp_r, bus.disp_g, bus.disp_b};
        wr_data[FLAG_SOF]           = sof_pend_q;
        wr_data[FLAG_EOL]           = (bus.disp_x == X_LAST);
    end

    // capture sequencing: arm, wait for frame start, write pixels, drain
    always_comb begin
        state_d    = state_q;
        sof_pend_d = sof_pend_q;
        overflow_d = overflow_q;
        short_d    = short_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_WAIT_FRAME;
                    overflow_d = 1'b0;
                    short_d    = 1'b0;
                end
            end
            ST_WAIT_FRAME: begin
                if (bus.disp_frame) begin
                    state_d    = ST_CAPTURE;
                    sof_pend_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (bus.disp_frame) begin
                    // new frame began before the last pixel: this cycle's pixel is discarded
                    short_d = 1'b1;
                    state_d = ST_FLUSH;
                end else if (bus.disp_de) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                        state_d    = ST_FLUSH;
                    end else begin
                        wr_en      = 1'b1;
                        sof_pend_d = 1'b0;
                        if (bus.disp_x == X_LAST && bus.disp_y == Y_LAST) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and sticky flag registers
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q    <= ST_IDLE;
            sof_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sof_pend_q <= sof_pend_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_disp_capture.sv
// tb/tb_disp_capture.sv - self-checking bench for disp_capture
module tb_disp_capture;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int LINE = H + 2;
    localparam int NCYC = 2 + V * LINE + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic arm;
    logic signed [15:0] dx, dy;
    logic de, fr;
    logic [7:0] pr, pg, pb;
    logic ready16, ready4;
    logic busy16, done16, ov16, sf16;
    logic busy4, done4, ov4, sf4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rmode = 0;

    logic [23:0] pix [8];
    logic [25:0] got0[$];
    logic [25:0] got1[$];
    int rp0 = 0, rp1 = 0;
    int done_cnt[2], done_gap[2], last_pop[2], busy_cnt[2], stab_bad[2];
    logic stall[2];
    logic [25:0] held[2];

    disp_capture_if #(.BPC_BOARD(8), .CORDW(16)) bus16 ();
    disp_capture_if #(.BPC_BOARD(8), .CORDW(16)) bus4 ();

    assign bus16.disp_x = dx;  assign bus4.disp_x = dx;
    assign bus16.disp_y = dy;  assign bus4.disp_y = dy;
    assign bus16.disp_de = de; assign bus4.disp_de = de;
    assign bus16.disp_frame = fr; assign bus4.disp_frame = fr;
    assign bus16.disp_r = pr;  assign bus4.disp_r = pr;
    assign bus16.disp_g = pg;  assign bus4.disp_g = pg;
    assign bus16.disp_b = pb;  assign bus4.disp_b = pb;
    assign bus16.out_ready = ready16;
    assign bus4.out_ready  = ready4;

    disp_capture #(.BPC_BOARD(8), .CORDW(16), .H_RES(H), .V_RES(V), .FIFO_DEPTH(16)) u_dut16 (
        .clk_pix(clk), .rst_pix_n(rst_n), .arm(arm), .bus(bus16),
        .busy(busy16), .done(done16), .overflow(ov16), .short_frame(sf16));

    disp_capture #(.BPC_BOARD(8), .CORDW(16), .H_RES(H), .V_RES(V), .FIFO_DEPTH(4)) u_dut4 (
        .clk_pix(clk), .rst_pix_n(rst_n), .arm(arm), .bus(bus4),
        .busy(busy4), .done(done4), .overflow(ov4), .short_frame(sf4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int d, input logic v, input logic rdy, input logic [25:0] w,
                       input logic dn, input logic bz);
        if (bz) busy_cnt[d]++;
        if (stall[d] && v && (w !== held[d])) stab_bad[d]++;
        stall[d] = v && !rdy;
        held[d]  = w;
        if (v && rdy) begin
            if (d == 0) got0.push_back(w); else got1.push_back(w);
            last_pop[d] = cyc;
        end
        if (dn) begin
            done_cnt[d]++;
            done_gap[d] = cyc - last_pop[d];
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            mon(0, bus16.out_valid, ready16, {bus16.out_data, bus16.out_sof, bus16.out_eol}, done16, busy16);
            mon(1, bus4.out_valid, ready4, {bus4.out_data, bus4.out_sof, bus4.out_eol}, done4, busy4);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rmode == 1)      ready16 = 1'($urandom_range(0, 1));
        else if (rmode == 2) ready16 = ~ready16;
        else                 ready16 = 1'b1;
    endtask

    // expected word i of a capture: pixel value, sof on the first, eol at each line end
    function automatic logic [25:0] expw(input int i);
        return {pix[i], 1'(i == 0), 1'((i % H) == H - 1)};
    endfunction

    task automatic rand_pix();
        for (int i = 0; i < 8; i++) pix[i] = 24'($urandom);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drive_frame(input int short_after, input int arm_at, input int rst_at);
        int np = 0;
        bit inj = 0;
        int x, y;
        logic e;
        for (int k = 0; k < NCYC; k++) begin
            if (k < 2) begin
                x = k - 2; y = -1; e = 1'b0;
            end else if (k < 2 + V * LINE) begin
                y = (k - 2) / LINE;
                x = (k - 2) % LINE - 2;
                e = (x >= 0);
            end else begin
                x = -2; y = -1; e = 1'b0;
            end
            fr = (k == 0);
            if (short_after >= 0 && np == short_after && !inj && e) begin
                fr  = 1'b1;
                inj = 1;
            end
            arm = (k == arm_at);
            dx = 16'(x);
            dy = 16'(y);
            de = e;
            if (e && np < 8) {pr, pg, pb} = pix[np];
            else             {pr, pg, pb} = 24'($urandom);
            if (k == rst_at) begin
                chk("t7_busy_before_reset", busy16, 1);
                rst_n = 1'b0;
                #1;
                chk("t7_valid16_in_reset", bus16.out_valid, 0);
                chk("t7_busy16_in_reset", busy16, 0);
                chk("t7_valid4_in_reset", bus4.out_valid, 0);
                chk("t7_busy4_in_reset", busy4, 0);
            end
            step();
            if (k == rst_at) rst_n = 1'b1;
            if (e) np++;
        end
        fr = 1'b0; de = 1'b0; arm = 1'b0;
    endtask

    task automatic wait_idle(input bit both);
        for (int i = 0; i < 300; i++) begin
            if (!busy16 && (!both || !busy4)) break;
            step();
        end
        chk("idle_timeout", busy16 || (both && busy4), 0);
        step();
        step();
    endtask

    task automatic verify(input string tag, input int n0, input int n1);
        int s0, s1;
        s0 = got0.size() - rp0;
        s1 = got1.size() - rp1;
        chk({tag, "_count16"}, s0, n0);
        for (int i = 0; i < n0 && i < s0; i++) chk($sformatf("%s_word16_%0d", tag, i), got0[rp0 + i], expw(i));
        chk({tag, "_count4"}, s1, n1);
        for (int i = 0; i < n1 && i < s1; i++) chk($sformatf("%s_word4_%0d", tag, i), got1[rp1 + i], expw(i));
        rp0 = got0.size();
        rp1 = got1.size();
    endtask

    initial begin
        int d0, d1, b0, b1, sb0;
        rst_n = 1'b0; arm = 1'b0; fr = 1'b0; de = 1'b0;
        dx = -16'sd2; dy = -16'sd1; {pr, pg, pb} = '0;
        ready16 = 1'b1; ready4 = 1'b1;
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0; done_gap[d] = 0; last_pop[d] = 0;
            busy_cnt[d] = 0; stab_bad[d] = 0;
        end
        repeat (3) step();
        chk("rst_valid", bus16.out_valid, 0);
        chk("rst_data", bus16.out_data, 0);
        chk("rst_sof", bus16.out_sof, 0);
        chk("rst_eol", bus16.out_eol, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_overflow", ov16, 0);
        chk("rst_short", sf16, 0);
        rst_n = 1'b1;
        step();

        // basic capture with known pixel values
        for (int i = 0; i < 8; i++) pix[i] = 24'(i + 1);
        d0 = done_cnt[0]; d1 = done_cnt[1];
        arm_pulse();
        drive_frame(-1, -1, -1);
        wait_idle(1);
        verify("t1", 8, 8);
        chk("t1_done16", done_cnt[0] - d0, 1);
        chk("t1_done4", done_cnt[1] - d1, 1);
        chk("t1_done_gap", done_gap[0], 2);
        chk("t1_overflow", ov16, 0);

        // frame without arm is ignored
        rand_pix();
        d0 = done_cnt[0]; b0 = busy_cnt[0]; b1 = busy_cnt[1];
        drive_frame(-1, -1, -1);
        wait_idle(1);
        verify("t2", 0, 0);
        chk("t2_done", done_cnt[0] - d0, 0);
        chk("t2_busy16", busy_cnt[0] - b0, 0);
        chk("t2_busy4", busy_cnt[1] - b1, 0);

        // arm mid-frame: the next frame is captured
        rand_pix();
        drive_frame(-1, 5, -1);
        verify("t3_pre", 0, 0);
        rand_pix();
        drive_frame(-1, -1, -1);
        wait_idle(1);
        verify("t3", 8, 8);

        // overflow on the depth-4 instance with its consumer stalled
        rand_pix();
        rmode = 1; ready4 = 1'b0;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        arm_pulse();
        drive_frame(-1, -1, -1);
        wait_idle(0);
        chk("t4_ov4", ov4, 1);
        chk("t4_busy4_stalled", busy4, 1);
        chk("t4_ov16", ov16, 0);
        chk("t4_sf4", sf4, 0);
        ready4 = 1'b1;
        wait_idle(1);
        verify("t4", 8, 4);
        chk("t4_done16", done_cnt[0] - d0, 1);
        chk("t4_done4", done_cnt[1] - d1, 1);
        chk("t4_done_gap4", done_gap[1], 2);
        chk("t4_ov4_held", ov4, 1);

        // short frame: new frame pulse after five pixels
        rmode = 0;
        rand_pix();
        d0 = done_cnt[0];
        arm_pulse();
        chk("t5_ov4_cleared", ov4, 0);
        drive_frame(5, -1, -1);
        wait_idle(1);
        verify("t5", 5, 5);
        chk("t5_sf16", sf16, 1);
        chk("t5_sf4", sf4, 1);
        chk("t5_done", done_cnt[0] - d0, 1);
        arm_pulse();
        chk("t5_sf_cleared", sf16, 0);
        rand_pix();
        drive_frame(-1, -1, -1);
        wait_idle(1);
        verify("t5_next", 8, 8);

        // alternating then random backpressure on the depth-16 instance
        sb0 = stab_bad[0];
        rmode = 2;
        rand_pix();
        arm_pulse();
        drive_frame(-1, -1, -1);
        wait_idle(1);
        verify("t6_alt", 8, 8);
        rmode = 1;
        for (int it = 0; it < 3; it++) begin
            rand_pix();
            arm_pulse();
            drive_frame(-1, -1, -1);
            wait_idle(1);
            verify($sformatf("t6_rnd%0d", it), 8, 8);
        end
        chk("t6_stable", stab_bad[0] - sb0, 0);

        // reset in the middle of a capture
        rmode = 0;
        rand_pix();
        d0 = done_cnt[0]; d1 = done_cnt[1];
        arm_pulse();
        drive_frame(-1, -1, 6);
        repeat (4) step();
        chk("t7_busy_after", busy16, 0);
        chk("t7_valid_after", bus16.out_valid, 0);
        chk("t7_no_done16", done_cnt[0] - d0, 0);
        chk("t7_no_done4", done_cnt[1] - d1, 0);
        rp0 = got0.size();
        rp1 = got1.size();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
